// File: rtl/riscv_mem_pkg.sv
// Shared load/store encodings, MEM sequencer state encoding and access-size
// helpers for the data-side memory path.
package riscv_mem_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } acc_size_e;

  // Unknown encodings fall through to word size.
  function automatic acc_size_e ld_size(input logic [2:0] sel);
    case (sel)
      LB, LBU: return SZ_BYTE;
      LH, LHU: return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic acc_size_e st_size(input logic [2:0] sel);
    case (sel)
      SB:      return SZ_BYTE;
      SH:      return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input acc_size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_HALF: return lo[0];
      SZ_WORD: return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane alignment for a 32-bit data bus.
//  Request side : we, ld_sel, st_sel, addr_lo, wdata -> be, wdata_lane, misalign
//  Response side: ext_sel, ext_addr_lo, rdata        -> ext_data (extended load)
module dmem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  ld_sel,
  input  logic [2:0]  st_sel,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic        misalign,
  input  logic [2:0]  ext_sel,
  input  logic [1:0]  ext_addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] ext_data
);

  acc_size_e   size;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    size       = we ? st_size(st_sel) : ld_size(ld_sel);
    misalign   = is_misaligned(size, addr_lo);
    be         = 4'hF;
    wdata_lane = wdata;
    if (we) begin
      case (size)
        SZ_BYTE: begin
          be         = 4'b0001 << addr_lo;
          wdata_lane = {4{wdata[7:0]}};
        end
        SZ_HALF: begin
          be         = 4'b0011 << addr_lo;
          wdata_lane = {2{wdata[15:0]}};
        end
        default: begin
          be         = 4'hF;
          wdata_lane = wdata;
        end
      endcase
    end
  end

  always_comb begin
    byte_v = rdata[8*ext_addr_lo +: 8];
    half_v = ext_addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (ext_sel)
      LB:      ext_data = {{24{byte_v[7]}}, byte_v};
      LBU:     ext_data = {24'h0, byte_v};
      LH:      ext_data = {{16{half_v[15]}}, half_v};
      LHU:     ext_data = {16'h0, half_v};
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: turns the load/store held in EX/MEM into a
// valid/ready bus transaction and stalls the pipeline until it completes.
//  Pipeline side: rd_en_M, wr_en_M, load_sel_M, store_sel_M, addr_M, wdata_M in;
//                 stall_M, load_data_M, misalign_M, bus_err out.
//  Bus side     : bus_req, bus_we, bus_addr, bus_be, bus_wdata out;
//                 bus_ready, bus_rvalid, bus_rdata in.
module dmem_access_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned CNT_W       = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en_M,
  input  logic        wr_en_M,
  input  logic [2:0]  load_sel_M,
  input  logic [2:0]  store_sel_M,
  input  logic [31:0] addr_M,
  input  logic [31:0] wdata_M,
  output logic        stall_M,
  output logic [31:0] load_data_M,
  output logic        misalign_M,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  mem_state_e       state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       sel_q;
  logic [1:0]       addr_lo_q;

  logic        access;
  logic        timeout;
  logic        mis_c;
  logic        misalign_c;
  logic        err_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] ext_data;

  assign access  = rd_en_M | wr_en_M;
  assign timeout = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  dmem_lane_align u_align (
    .we          (wr_en_M),
    .ld_sel      (load_sel_M),
    .st_sel      (store_sel_M),
    .addr_lo     (addr_M[1:0]),
    .wdata       (wdata_M),
    .be          (be_c),
    .wdata_lane  (wdata_c),
    .misalign    (mis_c),
    .ext_sel     (sel_q),
    .ext_addr_lo (addr_lo_q),
    .rdata       (bus_rdata),
    .ext_data    (ext_data)
  );

  // Acceptance / rvalid take priority over a timeout landing in the same cycle.
  always_comb begin
    state_n    = state;
    misalign_c = 1'b0;
    err_c      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (access) begin
          if (mis_c) misalign_c = 1'b1;
          else       state_n    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus_ready) begin
          state_n = bus_we ? ST_DONE : ST_WAIT;
        end else if (timeout) begin
          err_c   = 1'b1;
          state_n = ST_DONE;
        end
      end
      ST_WAIT: begin
        if (bus_rvalid) begin
          state_n = ST_DONE;
        end else if (timeout) begin
          err_c   = 1'b1;
          state_n = ST_DONE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Combinational flags are gated by rst so every output reads 0 while reset is held.
  assign stall_M    = ~rst & access & (state != ST_DONE) & ~misalign_c;
  assign misalign_M = ~rst & misalign_c;
  assign bus_err    = ~rst & err_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      sel_q       <= '0;
      addr_lo_q   <= '0;
      load_data_M <= '0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_be      <= '0;
      bus_wdata   <= '0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: begin
          if (access) begin
            if (mis_c) begin
              if (!wr_en_M) load_data_M <= '0;
            end else begin
              cnt       <= '0;
              bus_req   <= 1'b1;
              bus_we    <= wr_en_M;
              bus_addr  <= {addr_M[31:2], 2'b00};
              bus_be    <= be_c;
              bus_wdata <= wr_en_M ? wdata_c : '0;
              sel_q     <= load_sel_M;
              addr_lo_q <= addr_M[1:0];
            end
          end
        end
        ST_REQ: begin
          cnt <= cnt + 1'b1;
          if (bus_ready || timeout) bus_req <= 1'b0;
          if (!bus_ready && timeout) load_data_M <= '0;
        end
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          if (bus_rvalid)   load_data_M <= ext_data;
          else if (timeout) load_data_M <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en_M, wr_en_M;
  logic [2:0]  load_sel_M, store_sel_M;
  logic [31:0] addr_M, wdata_M;
  logic        stall_M;
  logic [31:0] load_data_M;
  logic        misalign_M, bus_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready, bus_rvalid;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  txn_t        txn_q[$];
  logic [31:0] ld_q[$];

  always #5 clk = ~clk;

  dmem_access_ctrl #(.TIMEOUT_CYC(8), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en_M     (rd_en_M),
    .wr_en_M     (wr_en_M),
    .load_sel_M  (load_sel_M),
    .store_sel_M (store_sel_M),
    .addr_M      (addr_M),
    .wdata_M     (wdata_M),
    .stall_M     (stall_M),
    .load_data_M (load_data_M),
    .misalign_M  (misalign_M),
    .bus_err     (bus_err),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_be      (bus_be),
    .bus_wdata   (bus_wdata),
    .bus_ready   (bus_ready),
    .bus_rvalid  (bus_rvalid),
    .bus_rdata   (bus_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one access from its IDLE cycle until the first non-stalled cycle
  // (DONE), acting as the bus slave. rv_dly counts cycles after acceptance
  // before rvalid (negative = never). Returns with the DUT in its DONE cycle.
  task automatic run_access(
    input  string       tag,
    input  logic        we,
    input  logic [2:0]  sel,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  int          rdy_dly,
    input  int          rv_dly,
    input  logic [3:0]  exp_be,
    input  logic [31:0] exp_wdata,
    input  logic [31:0] exp_ld,
    output int          stall_cyc,
    output int          req_cyc,
    output int          err_idx,
    output int          err_n
  );
    txn_t t, got;
    int   k, idx;
    bit   accepted, in_tx, done;
    @(negedge clk);
    rd_en_M     = ~we;
    wr_en_M     = we;
    load_sel_M  = sel;
    store_sel_M = sel;
    addr_M      = addr;
    wdata_M     = wdata;
    bus_ready   = 1'b0;
    bus_rvalid  = 1'b0;
    t.we = we; t.addr = {addr[31:2], 2'b00}; t.be = exp_be; t.wdata = exp_wdata;
    txn_q.push_back(t);
    if (!we) ld_q.push_back(exp_ld);
    stall_cyc = 0; req_cyc = 0; err_idx = -1; err_n = 0;
    k = 0; idx = -1; accepted = 0; in_tx = 0; done = 0;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) @(negedge clk);
      if (bus_req) in_tx = 1;
      if (in_tx) idx++;
      bus_ready  = bus_req && (req_cyc >= rdy_dly);
      bus_rvalid = 1'b0;
      if (accepted) begin
        k++;
        if (k == rv_dly) begin
          bus_rvalid = 1'b1;
          bus_rdata  = rdata;
        end
      end
      #1;
      if (bus_err) begin
        err_n++;
        if (err_idx < 0) err_idx = idx;
      end
      if (bus_req) req_cyc++;
      if (bus_req && bus_ready) begin
        check({tag, "_txn_expected"}, 32'(txn_q.size() != 0), 32'd1);
        if (txn_q.size() != 0) begin
          got = txn_q.pop_front();
          check({tag, "_bus_we"},   32'(bus_we), 32'(got.we));
          check({tag, "_bus_addr"}, bus_addr, got.addr);
          check({tag, "_bus_be"},   32'(bus_be), 32'(got.be));
          if (got.we) check({tag, "_bus_wdata"}, bus_wdata, got.wdata);
        end
        accepted = 1;
      end
      if (stall_M) stall_cyc++;
      else begin
        done = 1;
        break;
      end
    end
    check({tag, "_completed"}, 32'(done), 32'd1);
    if (!we && ld_q.size() != 0) check({tag, "_load_data"}, load_data_M, ld_q.pop_front());
    rd_en_M    = 1'b0;
    wr_en_M    = 1'b0;
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
  endtask

  int sc, rc, ei, en;

  initial begin
    rst = 1'b1;
    rd_en_M = 1'b1; wr_en_M = 1'b0; load_sel_M = LW; store_sel_M = SW;
    addr_M = 32'h101; wdata_M = '0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;

    // Reset state, with a misaligned load presented during reset
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall",     32'(stall_M), 32'd0);
    check("rst_misalign",  32'(misalign_M), 32'd0);
    check("rst_bus_err",   32'(bus_err), 32'd0);
    check("rst_bus_req",   32'(bus_req), 32'd0);
    check("rst_bus_we",    32'(bus_we), 32'd0);
    check("rst_bus_addr",  bus_addr, 32'd0);
    check("rst_bus_be",    32'(bus_be), 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_load_data", load_data_M, 32'd0);
    rd_en_M = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Stores: zero-wait bus, 2 stalled cycles then DONE
    run_access("sw", 1'b1, SW, 32'h100, 32'hDEADBEEF, '0, 0, -1, 4'hF, 32'hDEADBEEF, '0, sc, rc, ei, en);
    check("sw_stall_cycles", 32'(sc), 32'd2);
    check("sw_req_cycles",   32'(rc), 32'd1);
    run_access("sb", 1'b1, SB, 32'h103, 32'h000000A5, '0, 0, -1, 4'b1000, 32'hA5A5A5A5, '0, sc, rc, ei, en);
    run_access("sh", 1'b1, SH, 32'h102, 32'h1234BEEF, '0, 0, -1, 4'b1100, 32'hBEEFBEEF, '0, sc, rc, ei, en);
    // Bus holds off acceptance for 2 cycles: request must stay up
    run_access("sb_wait", 1'b1, SB, 32'h205, 32'h0000003C, '0, 2, -1, 4'b0010, 32'h3C3C3C3C, '0, sc, rc, ei, en);
    check("sb_wait_req_cycles",   32'(rc), 32'd3);
    check("sb_wait_stall_cycles", 32'(sc), 32'd4);

    // Loads: extraction and extension
    run_access("lb",  1'b0, LB,  32'h102, '0, 32'h12F03456, 0, 3, 4'hF, '0, 32'hFFFFFFF0, sc, rc, ei, en);
    check("lb_stall_cycles", 32'(sc), 32'd5);
    run_access("lbu", 1'b0, LBU, 32'h102, '0, 32'h12F03456, 0, 3, 4'hF, '0, 32'h000000F0, sc, rc, ei, en);
    run_access("lhu", 1'b0, LHU, 32'h102, '0, 32'h12F03456, 0, 3, 4'hF, '0, 32'h000012F0, sc, rc, ei, en);
    run_access("lh",  1'b0, LH,  32'h200, '0, 32'h00008001, 0, 1, 4'hF, '0, 32'hFFFF8001, sc, rc, ei, en);
    run_access("lw",  1'b0, LW,  32'h200, '0, 32'hCAFEF00D, 0, 1, 4'hF, '0, 32'hCAFEF00D, sc, rc, ei, en);
    check("lw_stall_cycles", 32'(sc), 32'd3);

    // Misaligned word load: flag, no stall, no request, load data cleared
    @(negedge clk);
    rd_en_M = 1'b1; load_sel_M = LW; addr_M = 32'h101;
    #1;
    check("mis_flag",    32'(misalign_M), 32'd1);
    check("mis_stall",   32'(stall_M), 32'd0);
    check("mis_bus_req", 32'(bus_req), 32'd0);
    @(negedge clk);
    rd_en_M = 1'b0;
    #1;
    check("mis_flag_drop", 32'(misalign_M), 32'd0);
    check("mis_load_data", load_data_M, 32'd0);
    check("mis_no_req",    32'(bus_req), 32'd0);

    // Restore nonzero load data, then a load that times out
    run_access("lw2", 1'b0, LW, 32'h300, '0, 32'h0BADF00D, 0, 2, 4'hF, '0, 32'h0BADF00D, sc, rc, ei, en);
    run_access("tmo", 1'b0, LW, 32'h300, '0, '0, 0, -1, 4'hF, '0, 32'h0, sc, rc, ei, en);
    check("tmo_err_index", 32'(ei), 32'd7);
    check("tmo_err_count", 32'(en), 32'd1);
    check("tmo_bus_req",   32'(bus_req), 32'd0);
    // Late rvalid in DONE and then IDLE must be ignored
    bus_rvalid = 1'b1; bus_rdata = 32'h55555555;
    @(negedge clk);
    #1;
    check("late_rvalid_ld",    load_data_M, 32'd0);
    check("late_rvalid_stall", 32'(stall_M), 32'd0);
    bus_rvalid = 1'b0;

    // Async reset while a request is pending
    run_access("lw3", 1'b0, LW, 32'h400, '0, 32'h76543210, 0, 1, 4'hF, '0, 32'h76543210, sc, rc, ei, en);
    @(negedge clk);
    rd_en_M = 1'b1; load_sel_M = LW; addr_M = 32'h404; bus_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("pre_rst_bus_req", 32'(bus_req), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_bus_req",   32'(bus_req), 32'd0);
    check("arst_stall",     32'(stall_M), 32'd0);
    check("arst_load_data", load_data_M, 32'd0);
    check("arst_bus_addr",  bus_addr, 32'd0);
    check("arst_bus_be",    32'(bus_be), 32'd0);
    rd_en_M = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    bus_rvalid = 1'b0;
    #1;
    check("post_rst_rvalid_ld", load_data_M, 32'd0);
    check("post_rst_bus_req",   32'(bus_req), 32'd0);

    // Recovery after reset
    run_access("sw_after", 1'b1, SW, 32'h500, 32'h13579BDF, '0, 0, -1, 4'hF, 32'h13579BDF, '0, sc, rc, ei, en);
    check("sw_after_stall_cycles", 32'(sc), 32'd2);

    check("txn_queue_empty", 32'(txn_q.size()), 32'd0);
    check("ld_queue_empty",  32'(ld_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
